arcade_input_ctrl: RTL and testbench
====================================

Name: arcade_input_ctrl

Overview:
- Parametrised player-input and DIP/game-select front end for the multi-game SNK arcade cores.
- Sits between hps_io (joystick words, ioctl bus) and the game core's active-low PLAYER/DSW/GAME inputs.
- Generalises per-core joystick mapping to N players and adds:
  - metastability sync
  - fixed-width coin pulses
  - opposing-direction cleanup
  - pause toggle
  - validated DIP/game-byte capture

Parameters:
- NUM_PLAYERS, 2, players mapped (1..4).
- NUM_DSW, 2, DIP bytes captured (1..8).
- DSW_DEFAULT, all-ones (NUM_DSW*8 bits), DIP value after reset.
- DSW_INDEX, 254, ioctl_index carrying DIP bytes.
- GAME_INDEX, 1, ioctl_index whose byte 0 is the game select.
- COIN_CYC, 1072000, coin_n low width in clk_sys cycles (20 ms @ 53.6 MHz); counter width is clog2(COIN_CYC+1).
- SOCD_NEUTRAL, 1, 1 = opposing directions both pressed read as neither.

Ports:
- clk_sys  in  1  system clock (53.6 MHz).
- reset  in  1  asynchronous, active-high reset.
- inputs_en  in  1  0 forces all player outputs idle and clears coin/pause state (driven low during core reset/download).
- joystick  in  NUM_PLAYERS*16  hps_io joystick words, player p at [16p+15:16p], active-high.
  - bits: 0 R, 1 L, 2 D, 3 U, 4 fire, 5 missile, 6 armor, 7 start1, 8 coin, 9 pause, 10 service, 11 start2.
- ioctl_wr  in  1  ioctl write strobe.
- ioctl_index  in  8  ioctl index.
- ioctl_addr  in  25  ioctl byte address.
- ioctl_dout  in  8  ioctl data.
- player_out  out  NUM_PLAYERS*16  active-low packed words, player p at [16p+15:16p].
- dsw  out  NUM_DSW*8  DIP bytes, byte k at [8k+7:8k].
- dsw_valid  out  1  all NUM_DSW bytes written since reset.
- game  out  8  game select byte.
- game_valid  out  1  game byte written since reset.
- pause  out  1  active-high pause request.

Behaviour:
- Reset values:
  - player_out = all ones.
  - dsw = DSW_DEFAULT.
  - dsw_valid = 0, game = 0, game_valid = 0, pause = 0.
  - Coin counters = 0; sync and edge registers = 0.
- Sync: joystick passes through 2 flip-flop stages. Edge detection uses stage-2 value vs its previous value.
- Output word per player (after registering), bit positions:
  - 15:14 = 1
  - 13 up_n, 12 down_n, 11 right_n, 10 left_n
  - 9 service_n
  - 8 start2_n (player 0 only; other players drive 1)
  - 7:5 = 1
  - 4 armor_n, 3 missile_n, 2 fire_n, 1 start_n, 0 coin_n
- Latency: every non-coin bit reaches player_out 3 cycles after the joystick input changes (2 sync + 1 output register).
- SOCD: with SOCD_NEUTRAL=1, U&D both set gives up_n=down_n=1; L&R both set gives left_n=right_n=1. With 0, bits pass through unchanged.
- Coin (per player), FSM IDLE -> ACTIVE -> HOLD:
  - IDLE: a coin rising edge loads the counter with COIN_CYC and goes to ACTIVE. coin_n goes low in the same cycle the other bits would update.
  - ACTIVE: coin_n = 0; the counter decrements each cycle. When it reaches 1, coin_n = 1 on the next cycle. Go to HOLD if the button is still held, else IDLE.
  - HOLD: coin_n = 1 until the button releases, then IDLE.
  - Net effect: exactly COIN_CYC low cycles per press; holding never produces a second coin; edges during ACTIVE are ignored.
- Pause:
  - A rising edge of bit 9 from any player toggles pause.
  - Simultaneous edges from several players in one cycle produce a single toggle.
  - Pause does not mask any outputs.
- inputs_en = 0:
  - player_out forced to all ones on the next cycle.
  - Coin FSMs go to IDLE with counter 0; pause cleared.
  - Edge registers keep tracking, so a button held across the re-enable does not fire.
- DIP capture:
  - Condition: ioctl_wr && ioctl_index==DSW_INDEX && ioctl_addr < NUM_DSW.
  - Writes byte ioctl_addr in 1 cycle; addresses ≥ NUM_DSW are ignored.
  - Per-byte written flags are kept; dsw_valid = AND of the flags, registered.
  - Rewrites are allowed at any time and dsw_valid stays 1.
- Game capture: ioctl_wr && ioctl_index==GAME_INDEX && ioctl_addr==0 loads game and sets game_valid. Other addresses are ignored.
- DIP and game registers depend only on reset, never on inputs_en.
- Async reset mid-coin or mid-pause returns all state to reset values immediately.

Test Plan:
- Reset, then P0 joystick=0x0008 (up) -> player_out[15:0]=0xDFFF 3 cycles later; release -> 0xFFFF 3 cycles after release.
- COIN_CYC=5: P0 coin held 50 cycles -> bit0 low for exactly 5 cycles, then high for the rest of the hold. Release and press again -> a second 5-cycle pulse.
- SOCD_NEUTRAL=1: P1 joystick=0x000C (U+D) -> player_out[31:16]=0xFFFF. With SOCD_NEUTRAL=0 -> 0xCFFF.
- NUM_DSW=2: writes idx254 addr0=0x5A, then addr2=0x11 (ignored), then addr1=0xC3 -> dsw=0xC35A; dsw_valid rises only after the addr1 write. Write idx1 addr0=0x03 -> game=0x03, game_valid=1.
- P0 and P1 pause edges in the same cycle -> pause 0→1 once. Then inputs_en=0 -> pause=0, player_out all ones, dsw unchanged.
- Assert reset during an active coin pulse -> coin_n=1, counter 0, dsw=DSW_DEFAULT, dsw_valid=0 immediately.

Source files
------------

// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: player-input and DIP/game-select front end for the SNK
// arcade cores. Synchronises hps_io joystick words, builds active-low player
// words with SOCD cleanup and fixed-width coin pulses, tracks a pause toggle
// and captures DIP switch / game-select bytes from the ioctl download bus.
module arcade_input_ctrl #(
   parameter int                   NUM_PLAYERS  = 2,
   parameter int                   NUM_DSW      = 2,
   parameter logic [NUM_DSW*8-1:0] DSW_DEFAULT  = '1,
   parameter logic [7:0]           DSW_INDEX    = 8'd254,
   parameter logic [7:0]           GAME_INDEX   = 8'd1,
   parameter int                   COIN_CYC     = 1072000,
   parameter bit                   SOCD_NEUTRAL = 1'b1
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   input  logic                     inputs_en,
   input  logic [NUM_PLAYERS*16-1:0] joystick,
   input  logic                     ioctl_wr,
   input  logic [7:0]               ioctl_index,
   input  logic [24:0]              ioctl_addr,
   input  logic [7:0]               ioctl_dout,
   output logic [NUM_PLAYERS*16-1:0] player_out,
   output logic [NUM_DSW*8-1:0]     dsw,
   output logic                     dsw_valid,
   output logic [7:0]               game,
   output logic                     game_valid,
   output logic                     pause
);

   localparam int CW = $clog2(COIN_CYC + 1);
   localparam int JW = NUM_PLAYERS * 16;

   typedef enum logic [1:0] {
      COIN_IDLE,
      COIN_ACTIVE,
      COIN_HOLD
   } coin_state_t;

   logic [JW-1:0]          sync1;
   logic [JW-1:0]          sync2;
   logic [JW-1:0]          prev;
   logic [NUM_PLAYERS-1:0] pause_rise;
   logic [NUM_DSW-1:0]     dsw_written;
   logic                   dsw_hit;
   logic                   game_hit;

   // Two-stage synchroniser plus the previous stage-2 value for edge detection;
   // these keep tracking even while inputs are disabled.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= joystick;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
      logic [15:0] cur;
      logic [15:0] old;
      coin_state_t state;
      coin_state_t state_next;
      logic [CW-1:0] cnt;
      logic [CW-1:0] cnt_next;
      logic coin_low;
      logic up;
      logic down;
      logic left;
      logic right;
      logic [15:0] word;

      assign cur = sync2[16*g +: 16];
      assign old = prev[16*g +: 16];
      assign pause_rise[g] = cur[9] & ~old[9];
      assign player_out[16*g +: 16] = word;

      // Coin pulse state register.
      always_ff @(posedge clk_sys or posedge reset) begin
         if (reset) begin
            state <= COIN_IDLE;
            cnt   <= '0;
         end else begin
            state <= state_next;
            cnt   <= cnt_next;
         end
      end

      // Coin next-state: coin_low is the value coin_n takes at the next edge.
      always_comb begin
         state_next = state;
         cnt_next   = cnt;
         coin_low   = 1'b0;
         if (!inputs_en) begin
            state_next = COIN_IDLE;
            cnt_next   = '0;
         end else begin
            case (state)
               COIN_IDLE: begin
                  if (cur[8] && !old[8]) begin
                     state_next = COIN_ACTIVE;
                     cnt_next   = CW'(COIN_CYC);
                     coin_low   = 1'b1;
                  end
               end
               COIN_ACTIVE: begin
                  if (cnt == CW'(1)) begin
                     cnt_next   = '0;
                     state_next = cur[8] ? COIN_HOLD : COIN_IDLE;
                  end else begin
                     cnt_next = cnt - CW'(1);
                     coin_low = 1'b1;
                  end
               end
               COIN_HOLD: begin
                  if (!cur[8]) state_next = COIN_IDLE;
               end
               default: begin
                  state_next = COIN_IDLE;
                  cnt_next   = '0;
               end
            endcase
         end
      end

      // Direction cleanup: opposing pairs cancel when SOCD_NEUTRAL is set.
      always_comb begin
         up    = cur[3] & ~(SOCD_NEUTRAL & cur[2]);
         down  = cur[2] & ~(SOCD_NEUTRAL & cur[3]);
         right = cur[0] & ~(SOCD_NEUTRAL & cur[1]);
         left  = cur[1] & ~(SOCD_NEUTRAL & cur[0]);
      end

      // Registered active-low player word; idle while inputs are disabled.
      always_ff @(posedge clk_sys or posedge reset) begin
         if (reset) begin
            word <= '1;
         end else if (!inputs_en) begin
            word <= '1;
         end else begin
            word <= {2'b11, ~up, ~down, ~right, ~left, ~cur[10],
                     (g == 0) ? ~cur[11] : 1'b1, 3'b111,
                     ~cur[6], ~cur[5], ~cur[4], ~cur[7], ~coin_low};
         end
      end
   end

   // Pause toggles once per cycle in which any player shows a rising edge.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         pause <= 1'b0;
      end else if (!inputs_en) begin
         pause <= 1'b0;
      end else if (|pause_rise) begin
         pause <= ~pause;
      end
   end

   assign dsw_hit  = ioctl_wr && (ioctl_index == DSW_INDEX);
   assign game_hit = ioctl_wr && (ioctl_index == GAME_INDEX) && (ioctl_addr == '0);

   for (genvar k = 0; k < NUM_DSW; k++) begin : g_dsw
      // DIP byte k capture and its written flag.
      always_ff @(posedge clk_sys or posedge reset) begin
         if (reset) begin
            dsw[8*k +: 8]  <= DSW_DEFAULT[8*k +: 8];
            dsw_written[k] <= 1'b0;
         end else if (dsw_hit && ioctl_addr == 25'(k)) begin
            dsw[8*k +: 8]  <= ioctl_dout;
            dsw_written[k] <= 1'b1;
         end
      end
   end

   // DIP-valid flag and game-select capture.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         dsw_valid  <= 1'b0;
         game       <= '0;
         game_valid <= 1'b0;
      end else begin
         dsw_valid <= &dsw_written;
         if (game_hit) begin
            game       <= ioctl_dout;
            game_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl: a cycle-level behavioural model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_arcade_input_ctrl;

   localparam int CC = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] joy;
   logic        wr;
   logic [7:0]  idx;
   logic [24:0] addr;
   logic [7:0]  dout;

   logic [31:0] po, po_n;
   logic [15:0] dsw, dsw_n;
   logic        dv, dv_n, gv, gv_n, pause, pause_n;
   logic [7:0]  game, game_n;

   int n_checks = 0;
   int n_fail   = 0;
   int lows;

   always #5 clk = ~clk;

   arcade_input_ctrl #(.NUM_PLAYERS(2), .NUM_DSW(2), .DSW_DEFAULT(16'hFFFF),
                       .DSW_INDEX(8'd254), .GAME_INDEX(8'd1), .COIN_CYC(CC),
                       .SOCD_NEUTRAL(1'b1)) dut (
      .clk_sys(clk), .reset(rst), .inputs_en(en), .joystick(joy),
      .ioctl_wr(wr), .ioctl_index(idx), .ioctl_addr(addr), .ioctl_dout(dout),
      .player_out(po), .dsw(dsw), .dsw_valid(dv), .game(game),
      .game_valid(gv), .pause(pause));

   arcade_input_ctrl #(.NUM_PLAYERS(2), .NUM_DSW(2), .DSW_DEFAULT(16'hFFFF),
                       .DSW_INDEX(8'd254), .GAME_INDEX(8'd1), .COIN_CYC(CC),
                       .SOCD_NEUTRAL(1'b0)) dut_n (
      .clk_sys(clk), .reset(rst), .inputs_en(en), .joystick(joy),
      .ioctl_wr(wr), .ioctl_index(idx), .ioctl_addr(addr), .ioctl_dout(dout),
      .player_out(po_n), .dsw(dsw_n), .dsw_valid(dv_n), .game(game_n),
      .game_valid(gv_n), .pause(pause_n));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Joystick history: h1/h2/h3 = values sampled 1/2/3 edges ago.
   logic [31:0] h1, h2, h3;
   int          age [2];
   logic [1:0]  low;
   bit          any_p;
   logic        m_pause, m_dv, m_gv;
   logic [31:0] m_out, m_out_n;
   logic [15:0] m_dsw;
   logic [1:0]  m_flags;
   logic [7:0]  m_game;

   function automatic logic [15:0] word(input logic [15:0] j, input bit p0,
                                        input bit socd, input bit coin_low);
      bit u, d, l, r;
      u = j[3]; d = j[2]; r = j[0]; l = j[1];
      if (socd && u && d) begin u = 1'b0; d = 1'b0; end
      if (socd && l && r) begin l = 1'b0; r = 1'b0; end
      return {2'b11, !u, !d, !r, !l, !j[10], p0 ? !j[11] : 1'b1, 3'b111,
              !j[6], !j[5], !j[4], !j[7], !coin_low};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         h1 = '0; h2 = '0; h3 = '0;
         age[0] = -1; age[1] = -1;
         m_pause = 1'b0; m_out = '1; m_out_n = '1;
         m_dsw = 16'hFFFF; m_flags = '0; m_dv = 1'b0;
         m_game = '0; m_gv = 1'b0;
      end else begin
         m_dv = &m_flags;
         if (wr && idx == 8'd254) begin
            if (addr == 25'd0) begin m_dsw[7:0]  = dout; m_flags[0] = 1'b1; end
            else if (addr == 25'd1) begin m_dsw[15:8] = dout; m_flags[1] = 1'b1; end
         end
         if (wr && idx == 8'd1 && addr == 25'd0) begin m_game = dout; m_gv = 1'b1; end
         any_p = 1'b0;
         for (int p = 0; p < 2; p++) begin
            // age counts edges since the coin pulse started; rises are ignored
            // until the pulse plus its closing edge are over.
            if (!en) age[p] = -1;
            else if (age[p] >= 0 && age[p] < CC) age[p]++;
            else if (h2[16*p+8] && !h3[16*p+8]) age[p] = 0;
            else age[p] = -1;
            low[p] = (age[p] >= 0 && age[p] < CC);
            if (h2[16*p+9] && !h3[16*p+9]) any_p = 1'b1;
         end
         if (!en) m_pause = 1'b0;
         else if (any_p) m_pause = !m_pause;
         m_out   = en ? {word(h2[31:16], 0, 1, low[1]), word(h2[15:0], 1, 1, low[0])} : '1;
         m_out_n = en ? {word(h2[31:16], 0, 0, low[1]), word(h2[15:0], 1, 0, low[0])} : '1;
         h3 = h2; h2 = h1; h1 = joy;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst) begin
         check("player_out", po, m_out);
         check("player_out_socd0", po_n, m_out_n);
         check("pause", pause, m_pause);
         check("pause_socd0", pause_n, m_pause);
         check("dsw", dsw, m_dsw);
         check("dsw_socd0", dsw_n, m_dsw);
         check("dsw_valid", dv, m_dv);
         check("dsw_valid_socd0", dv_n, m_dv);
         check("game", game, m_game);
         check("game_socd0", game_n, m_game);
         check("game_valid", gv, m_gv);
         check("game_valid_socd0", gv_n, m_gv);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic count_low(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(negedge clk);
         if (po[0] === 1'b0) cnt++;
      end
   endtask

   task automatic ioctl_write(input logic [7:0] i, input logic [24:0] a, input logic [7:0] d);
      idx = i; addr = a; dout = d; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; joy = '0; wr = 1'b0; idx = '0; addr = '0; dout = '0;
      #1;
      check("reset_player_out", po, 32'hFFFF_FFFF);
      check("reset_dsw", dsw, 16'hFFFF);
      check("reset_dsw_valid", dv, 1'b0);
      check("reset_game", game, 8'h00);
      check("reset_game_valid", gv, 1'b0);
      check("reset_pause", pause, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      step(2);

      // Up: three-cycle latency each way.
      joy = 32'h0000_0008;
      step(2); check("up_before_latency", po[15:0], 16'hFFFF);
      step(1); check("up", po[15:0], 16'hDFFF);
      joy = '0;
      step(2); check("up_release_early", po[15:0], 16'hDFFF);
      step(1); check("up_release", po[15:0], 16'hFFFF);

      // Coin held 50 cycles: one 5-cycle pulse; re-press gives another.
      joy = 32'h0000_0100;
      count_low(50, lows); check("coin_width", lows, 5);
      check("coin_hold_high", po[0], 1'b1);
      joy = '0; step(5);
      joy = 32'h0000_0100;
      count_low(20, lows); check("coin_second", lows, 5);
      joy = '0; step(5);

      // SOCD on player 1.
      joy = 32'h000C_0000;
      step(3);
      check("socd_neutral", po[31:16], 16'hFFFF);
      check("socd_passthru", po_n[31:16], 16'hCFFF);
      joy = '0; step(3);

      // DIP capture, out-of-range address ignored.
      ioctl_write(8'd254, 25'd0, 8'h5A); step(2);
      check("dsw_byte0", dsw, 16'hFF5A); check("dsw_valid_partial", dv, 1'b0);
      ioctl_write(8'd254, 25'd2, 8'h11); step(2);
      check("dsw_addr2_ignored", dsw, 16'hFF5A); check("dsw_valid_still0", dv, 1'b0);
      ioctl_write(8'd254, 25'd1, 8'hC3); step(2);
      check("dsw_full", dsw, 16'hC35A); check("dsw_valid_set", dv, 1'b1);

      // Game select; non-zero address ignored.
      ioctl_write(8'd1, 25'd0, 8'h03); step(1);
      check("game_byte", game, 8'h03); check("game_valid_set", gv, 1'b1);
      ioctl_write(8'd1, 25'd1, 8'h77); step(1);
      check("game_addr1_ignored", game, 8'h03);

      // Simultaneous pause edges toggle once.
      joy = 32'h0200_0200;
      step(3); check("pause_on", pause, 1'b1);
      step(3); check("pause_single_toggle", pause, 1'b1);
      joy = '0; step(3);

      // Disable clears pause and idles outputs; DIP untouched.
      en = 1'b0; joy = 32'h0000_0008;
      step(1);
      check("disable_pause", pause, 1'b0);
      check("disable_player_out", po, 32'hFFFF_FFFF);
      check("disable_dsw", dsw, 16'hC35A);
      // Coin held across re-enable must not fire.
      joy = 32'h0000_0100; step(4);
      en = 1'b1;
      count_low(12, lows); check("coin_held_reenable", lows, 0);
      joy = '0; step(4);

      // Reset in the middle of a coin pulse.
      joy = 32'h0000_0100;
      step(5); check("coin_active_before_reset", po[0], 1'b0);
      #1 rst = 1'b1;
      #1;
      check("reset_mid_coin", po[0], 1'b1);
      check("reset_mid_dsw", dsw, 16'hFFFF);
      check("reset_mid_dsw_valid", dv, 1'b0);
      check("reset_mid_game_valid", gv, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step(3);
      joy = '0; step(12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
